// File: rtl/sr_cfg_pkg.sv
// Shared state encoding and sizing helpers for the shift-register config loader.
// Word counts and index widths are derived here so the top and the packer agree.
package sr_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        READOUT
    } state_t;

    localparam int SR_WIDTH  = 170;
    localparam int SR_WORD_W = 32;

    function automatic int calc_nwords(input int width, input int word_w);
        return (width + word_w - 1) / word_w;
    endfunction

    // A single-word image still needs a 1-bit index to keep port widths legal.
    function automatic int calc_idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    function automatic int word_lo(input int idx, input int word_w);
        return idx * word_w;
    endfunction

    localparam int NWORDS = calc_nwords(SR_WIDTH, SR_WORD_W);
    localparam int IDX_W  = calc_idx_w(NWORDS);

endpackage

// File: rtl/sr_word_packer.sv
// Word <-> image slicing: merges one stream word into the config image and
// splits the readback image into words, masking bits above WIDTH.
module sr_word_packer
    import sr_cfg_pkg::*;
#(
    parameter int WIDTH     = SR_WIDTH,
    parameter int WORD_W    = SR_WORD_W,
    parameter int NUM_WORDS = calc_nwords(WIDTH, WORD_W),
    parameter int IDX_BITS  = calc_idx_w(NUM_WORDS)
) (
    input  logic [WIDTH-1:0]    image_in,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [IDX_BITS-1:0] wr_idx,
    output logic [WIDTH-1:0]    image_out,
    input  logic [WIDTH-1:0]    rd_image,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [WORD_W-1:0]   rd_word
);

    localparam int PAD_W = NUM_WORDS * WORD_W;

    logic [PAD_W-1:0] rd_pad;

    // Only image bits that exist are written; excess bits of the last word fall away.
    always_comb begin
        image_out = image_in;
        for (int b = 0; b < WIDTH; b++) begin
            if (b / WORD_W == int'(wr_idx)) begin
                image_out[b] = wr_word[b % WORD_W];
            end
        end
    end

    always_comb begin
        rd_pad  = PAD_W'(rd_image);
        rd_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (w == int'(rd_idx)) begin
                rd_word = rd_pad[word_lo(w, WORD_W) +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/sr_cfg_loader.sv
// Config loader for the Top_SR shift-register driver: word load, start pulse,
// fixed shift wait, readback capture and word readout. SR_READBACK_CHECK_EN adds a sticky compare.
module sr_cfg_loader
    import sr_cfg_pkg::*;
#(
    parameter int WIDTH       = SR_WIDTH,
    parameter int WORD_W      = SR_WORD_W,
    parameter int START_LEN   = 2,
    parameter int WAIT_CYCLES = 400
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WIDTH-1:0]  sr_din,
    output logic              sr_start,
    input  logic [WIDTH-1:0]  sr_dout,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);

    localparam int NUM_WORDS = calc_nwords(WIDTH, WORD_W);
    localparam int IDX_BITS  = calc_idx_w(NUM_WORDS);
    localparam int START_W   = $clog2(START_LEN + 1);
    localparam int WAIT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

    state_t              state, state_next;
    logic [IDX_BITS-1:0] idx;
    logic [START_W-1:0]  start_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WIDTH-1:0]    image, image_next, readback;
    logic                wr_fire, rd_fire;

    assign wr_fire = (state == LOAD) && wr_valid;
    assign rd_fire = (state == READOUT) && rd_ready;
    assign sr_din  = image;

    sr_word_packer #(
        .WIDTH     (WIDTH),
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_BITS  (IDX_BITS)
    ) u_packer (
        .image_in  (image),
        .wr_word   (wr_data),
        .wr_idx    (idx),
        .image_out (image_next),
        .rd_image  (readback),
        .rd_idx    (idx),
        .rd_word   (rd_data)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The IDLE-exit word is left on the bus so LOAD consumes it as word 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_valid) state_next = LOAD;
            LOAD:    if (wr_valid && idx == LAST_IDX) state_next = START;
            START:   if (start_cnt == START_W'(START_LEN - 1)) state_next = WAIT;
            WAIT:    if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) state_next = CAPTURE;
            CAPTURE: state_next = READOUT;
            READOUT: if (rd_ready && idx == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state == LOAD);
        sr_start = (state == START);
        rd_valid = (state == READOUT);
        busy     = (state != IDLE);
        done     = rd_fire && (idx == LAST_IDX);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            start_cnt <= '0;
            wait_cnt  <= '0;
            image     <= '0;
            readback  <= '0;
        end else begin
            if (wr_fire || rd_fire) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            start_cnt <= (state == START && state_next == START) ? start_cnt + 1'b1 : '0;
            wait_cnt  <= (state == WAIT && state_next == WAIT) ? wait_cnt + 1'b1 : '0;
            if (wr_fire) begin
                image <= image_next;
            end
            if (state == CAPTURE) begin
                readback <= sr_dout;
            end
        end
    end

`ifdef SR_READBACK_CHECK_EN
    // Sticky until the next image starts loading, so a host can read it after done.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (state == CAPTURE && sr_dout != image) begin
            mismatch <= 1'b1;
        end else if (wr_fire && idx == '0) begin
            mismatch <= 1'b0;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cfg_loader.sv
// Directed bench for sr_cfg_loader with a Top_SR loopback model and a readback scoreboard.
// Build with SR_READBACK_CHECK_EN defined to expect the sticky mismatch flag.
module tb_sr_cfg_loader;

    localparam int WIDTH       = 170;
    localparam int WORD_W      = 32;
    localparam int NW          = 6;
    localparam int START_LEN   = 2;
    localparam int WAIT_CYCLES = 400;
    localparam int LATENCY     = START_LEN + WAIT_CYCLES + 2;
    localparam logic [31:0] LAST_MASK = 32'h0000_03FF;

`ifdef SR_READBACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [WIDTH-1:0]  sr_din;
    logic              sr_start;
    logic [WIDTH-1:0]  sr_dout;
    logic              busy;
    logic              done;
    logic              mismatch;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          wr_cycle = 0;
    int          rd_first = 0;
    int          hi;
    bit          flip     = 1'b0;
    logic [31:0] wr_words [NW];
    logic [31:0] exp_q [$];
    logic [WIDTH-1:0] exp_img;
    logic [9:0]  lb_cnt;
    logic        lb_armed;

    sr_cfg_loader #(
        .WIDTH       (WIDTH),
        .WORD_W      (WORD_W),
        .START_LEN   (START_LEN),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .sr_din   (sr_din),
        .sr_start (sr_start),
        .sr_dout  (sr_dout),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cycle <= cycle + 1;

    // Top_SR stand-in: parallel readback mirrors din 300 cycles after start falls, optionally with bit 3 inverted.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lb_armed <= 1'b0;
            lb_cnt   <= '0;
            sr_dout  <= '0;
        end else if (sr_start) begin
            lb_armed <= 1'b1;
            lb_cnt   <= '0;
            sr_dout  <= '0;
        end else if (lb_armed) begin
            lb_cnt <= lb_cnt + 1'b1;
            if (lb_cnt == 10'd299) begin
                sr_dout  <= sr_din ^ (flip ? WIDTH'(8) : WIDTH'(0));
                lb_armed <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [191:0] observed, input logic [191:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] buildImage();
        logic [NW*WORD_W-1:0] full;
        for (int i = 0; i < NW; i++) full[i*WORD_W +: WORD_W] = wr_words[i];
        return WIDTH'(full);
    endfunction

    // Drives the six words in order and queues the words expected back from readout.
    task automatic applyStimulus();
        int guard;
        logic [31:0] exp_word;
        for (int i = 0; i < NW; i++) begin
            exp_word = (i == NW - 1) ? (wr_words[i] & LAST_MASK) : wr_words[i];
            if (i == 0 && flip) exp_word = exp_word ^ 32'h8;
            exp_q.push_back(exp_word);
        end
        for (int i = 0; i < NW; i++) begin
            guard = 0;
            @(negedge clk_in);
            wr_valid = 1'b1;
            wr_data  = wr_words[i];
            #1;
            while (!wr_ready && guard < 50) begin
                @(negedge clk_in);
                #1;
                guard++;
            end
            if (!wr_ready) begin
                checkOutput("wr_timeout", wr_ready, 1);
                wr_valid = 1'b0;
                return;
            end
            if (i == NW - 1) wr_cycle = cycle;
            @(posedge clk_in);
            #1;
            wr_valid = 1'b0;
            if (i == 0) checkOutput("mismatch_clr", mismatch, 0);
        end
    endtask

    task automatic drainWords(input int stall_word);
        int n = 0;
        int guard = 0;
        bit first = 1'b1;
        logic [31:0] held;
        logic [31:0] exp_word;
        rd_ready = 1'b0;
        while (n < NW && guard < 1000) begin
            @(negedge clk_in);
            guard++;
            if (rd_valid) begin
                if (first) begin
                    rd_first = cycle;
                    first    = 1'b0;
                end
                if (n == stall_word) begin
                    rd_ready = 1'b0;
                    held     = rd_data;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk_in);
                        checkOutput("stall_valid", rd_valid, 1);
                        checkOutput("stall_data", rd_data, held);
                    end
                end
                rd_ready = 1'b1;
                #1;
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checkOutput("rd_word", rd_data, exp_word);
                checkOutput("done", done, (n == NW - 1));
                n++;
                guard = 0;
            end else begin
                rd_ready = 1'b0;
            end
        end
        checkOutput("rd_count", n, NW);
        @(negedge clk_in);
        rd_ready = 1'b0;
        #1;
        checkOutput("end_busy", busy, 0);
        checkOutput("end_done", done, 0);
        checkOutput("end_rd_valid", rd_valid, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_sr_start", sr_start, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sr_din", sr_din, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_mismatch", mismatch, 0);
        rst_n = 1'b1;
        @(negedge clk_in);

        $display("[TB] single-bit image, bits above WIDTH in word 5");
        wr_words = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0020_0000};
        applyStimulus();
        @(negedge clk_in);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_sr_din", sr_din, WIDTH'(1));
        checkOutput("t1_wr_ready", wr_ready, 0);
        hi = 0;
        while (sr_start && hi < 20) begin
            hi++;
            @(negedge clk_in);
        end
        checkOutput("t1_start_len", hi, START_LEN);
        drainWords(-1);
        checkOutput("t1_latency", rd_first - wr_cycle, LATENCY);
        checkOutput("t1_mismatch", mismatch, 0);

        $display("[TB] readout backpressure");
        for (int i = 0; i < NW; i++) wr_words[i] = $urandom;
        exp_img = buildImage();
        applyStimulus();
        repeat (100) @(negedge clk_in);
        checkOutput("t3_sr_din_hold", sr_din, exp_img);
        drainWords(2);

        $display("[TB] all-ones last word");
        for (int i = 0; i < NW - 1; i++) wr_words[i] = $urandom;
        wr_words[NW-1] = 32'hFFFF_FFFF;
        exp_img = buildImage();
        applyStimulus();
        @(negedge clk_in);
        checkOutput("t4_sr_din", sr_din, exp_img);
        checkOutput("t4_top_bits", sr_din[169:160], 10'h3FF);
        drainWords(-1);

        $display("[TB] reset during START and during WAIT");
        for (int i = 0; i < NW; i++) wr_words[i] = $urandom;
        applyStimulus();
        @(negedge clk_in);
        checkOutput("t5_start_hi", sr_start, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_start_drop", sr_start, 0);
        checkOutput("t5_busy_drop", busy, 0);
        exp_q.delete();
        @(negedge clk_in);
        rst_n = 1'b1;
        applyStimulus();
        repeat (50) @(negedge clk_in);
        checkOutput("t5_wait_busy", busy, 1);
        checkOutput("t5_wait_start", sr_start, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_rd_valid", rd_valid, 0);
        checkOutput("t5_rst_wr_ready", wr_ready, 0);
        checkOutput("t5_rst_sr_din", sr_din, 0);
        exp_q.delete();
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) wr_words[i] = $urandom;
        exp_img = buildImage();
        applyStimulus();
        @(negedge clk_in);
        checkOutput("t5_clean_sr_din", sr_din, exp_img);
        drainWords(-1);

        $display("[TB] readback bit 3 inverted");
        flip = 1'b1;
        for (int i = 0; i < NW; i++) wr_words[i] = $urandom;
        applyStimulus();
        drainWords(-1);
        checkOutput("t6_mismatch_after_done", mismatch, CHECK_EN);
        flip = 1'b0;
        for (int i = 0; i < NW; i++) wr_words[i] = $urandom;
        applyStimulus();
        drainWords(-1);
        checkOutput("t6_mismatch_clean", mismatch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
